// File: rtl/imem_load_ctrl.sv
// Instruction-memory port arbiter: a boot loader streams program words in,
// then the memory is handed to the core fetch path until the next start.
module imem_load_ctrl #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [31:0]   ld_addr,
   input  logic [31:0]   ld_data,
   input  logic          ld_last,
   input  logic [31:0]   fetch_addr,
   output logic [31:0]   fetch_instr,
   output logic          fetch_fault,
   output logic          cpu_run,
   output logic          load_err,
   output logic [AW:0]   words_loaded,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   localparam logic [31:0] MemBytes = 32'(DEPTH * 4);
   localparam logic [AW:0] WordsMax = (AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StDrain,
      StRun,
      StErr
   } state_e;

   state_e        state_q, state_d;
   logic          load_err_q, load_err_d;
   logic [AW:0]   words_q, words_d;
   // One-deep write pipeline between an accepted beat and the memory strobe.
   logic          wr_pend_q, wr_pend_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]   wr_data_q, wr_data_d;

   logic beat_acc;
   logic beat_bad;
   logic beat_good;
   logic run;

   assign beat_acc  = (state_q == StLoad) && ld_valid;
   assign beat_bad  = (ld_addr[1:0] != 2'b00) || (ld_addr >= MemBytes);
   assign beat_good = beat_acc && !beat_bad;
   assign run       = (state_q == StRun);

   // Next-state, sticky error, beat counter and write-pipeline capture.
   always_comb begin
      state_d    = state_q;
      load_err_d = load_err_q;
      words_d    = words_q;
      wr_pend_d  = beat_good;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      if (beat_good) begin
         wr_addr_d = ld_addr[AW+1:2];
         wr_data_d = ld_data;
      end

      unique case (state_q)
         StIdle: begin
            if (start) state_d = StLoad;
         end
         StLoad: begin
            if (start) begin
               state_d = StLoad;
            end else if (beat_acc && beat_bad) begin
               state_d = StErr;
            end else if (beat_good && ld_last) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            state_d = start ? StLoad : StRun;
         end
         StRun, StErr: begin
            if (start) state_d = StLoad;
         end
         default: state_d = StIdle;
      endcase

      // start wins over a same-cycle bad beat; a same-cycle good beat is still written.
      if (start) begin
         load_err_d = 1'b0;
         words_d    = '0;
      end else begin
         if (beat_acc && beat_bad) load_err_d = 1'b1;
         if (beat_good && (words_q != WordsMax)) words_d = words_q + 1'b1;
      end
   end

   // State and pipeline registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         load_err_q <= 1'b0;
         words_q    <= '0;
         wr_pend_q  <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         load_err_q <= load_err_d;
         words_q    <= words_d;
         wr_pend_q  <= wr_pend_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // Output decode: the pending write owns the port; fetch only drives it in RUN.
   always_comb begin
      ld_ready     = (state_q == StLoad);
      cpu_run      = run;
      load_err     = load_err_q;
      words_loaded = words_q;
      fetch_fault  = run && ((fetch_addr[1:0] != 2'b00) || (fetch_addr >= MemBytes));
      fetch_instr  = (run && !fetch_fault) ? mem_rdata : 32'h0;
      // A write still pending while reset is asserted is discarded.
      mem_we       = wr_pend_q && reset_n;
      mem_wdata    = wr_pend_q ? wr_data_q : 32'h0;
      if (wr_pend_q) begin
         mem_addr = wr_addr_q;
      end else if (run) begin
         mem_addr = fetch_addr[AW+1:2];
      end else begin
         mem_addr = '0;
      end
   end

endmodule
